// File: rtl/uart_rx_if.sv
// uart_rx_if: write side of the FIFO that sits behind the UART receiver.
//   wfifo_wr_data  received byte presented to the FIFO
//   wfifo_wr_en    one-cycle write strobe
//   wfifo_full     FIFO full flag, returned to the writer
// master = byte producer (uart_rx), slave = FIFO.
interface uart_rx_if;
  logic [7:0] wfifo_wr_data;
  logic       wfifo_wr_en;
  logic       wfifo_full;

  modport master (
    output wfifo_wr_data,
    output wfifo_wr_en,
    input  wfifo_full
  );

  modport slave (
    input  wfifo_wr_data,
    input  wfifo_wr_en,
    output wfifo_full
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, fixed baud. Each good byte is written
// into the downstream FIFO. Framing errors and bytes dropped on a full FIFO
// are reported as one-cycle pulses.
//   s_clk        system clock
//   s_rst_n      asynchronous active-low reset
//   data_rx      asynchronous serial line, idle high
//   wfifo        FIFO write port (wr_data / wr_en out, full in)
//   frame_err    pulse: stop bit sampled low
//   rx_overflow  pulse: good byte dropped because the FIFO was full
//   rx_busy      high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned BAND_TIME = 5207,
  parameter int unsigned HALF_TIME = BAND_TIME / 2
) (
  input  logic      s_clk,
  input  logic      s_rst_n,
  input  logic      data_rx,
  uart_rx_if.master wfifo,
  output logic      frame_err,
  output logic      rx_overflow,
  output logic      rx_busy
);

  localparam logic [12:0] BandMax = 13'(BAND_TIME);
  localparam logic [12:0] HalfMax = 13'(HALF_TIME);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      r_state;
  logic        r_sync1;
  logic        r_rx_s;
  logic        r_rx_d;
  logic [12:0] r_band_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_wr_data;
  logic        r_wr_en;
  logic        r_frame_err;
  logic        r_overflow;

  logic        w_start_edge;

  assign w_start_edge = r_rx_d & ~r_rx_s;

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state     <= StIdle;
      r_sync1     <= 1'b1;
      r_rx_s      <= 1'b1;
      r_rx_d      <= 1'b1;
      r_band_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_sync1     <= data_rx;
      r_rx_s      <= r_sync1;
      r_rx_d      <= r_rx_s;
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;

      unique case (r_state)
        StIdle: begin
          r_band_cnt <= '0;
          if (w_start_edge) begin
            r_state <= StStart;
          end
        end

        StStart: begin
          if (r_band_cnt == HalfMax) begin
            r_band_cnt <= '0;
            if (!r_rx_s) begin
              r_state   <= StData;
              r_bit_cnt <= '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              r_state <= StIdle;
            end
          end else begin
            r_band_cnt <= r_band_cnt + 13'd1;
          end
        end

        StData: begin
          if (r_band_cnt == BandMax) begin
            r_band_cnt <= '0;
            r_shift    <= {r_rx_s, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= StStop;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_band_cnt <= r_band_cnt + 13'd1;
          end
        end

        StStop: begin
          if (r_band_cnt == BandMax) begin
            // Leave at mid stop bit so a directly following start edge is seen.
            r_band_cnt <= '0;
            r_state    <= StIdle;
            if (r_rx_s) begin
              if (!wfifo.wfifo_full) begin
                r_wr_data <= r_shift;
                r_wr_en   <= 1'b1;
              end else begin
                r_overflow <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_band_cnt <= r_band_cnt + 13'd1;
          end
        end

        default: begin
          r_state    <= StIdle;
          r_band_cnt <= '0;
        end
      endcase
    end
  end

  assign wfifo.wfifo_wr_data = r_wr_data;
  assign wfifo.wfifo_wr_en   = r_wr_en;
  assign frame_err           = r_frame_err;
  assign rx_overflow         = r_overflow;
  assign rx_busy             = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; expected FIFO writes / error
// pulses are queued at stimulus time and checked by an independent monitor.
module tb_uart_rx;

  localparam int unsigned BT = 15;
  localparam int unsigned HT = BT / 2;

  typedef enum int {EvWr = 0, EvErr = 1, EvOvf = 2} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
  } ev_t;

  logic s_clk = 1'b0;
  logic s_rst_n;
  logic data_rx;
  logic frame_err;
  logic rx_overflow;
  logic rx_busy;

  uart_rx_if u_if ();

  uart_rx #(
    .BAND_TIME (BT),
    .HALF_TIME (HT)
  ) u_dut (
    .s_clk       (s_clk),
    .s_rst_n     (s_rst_n),
    .data_rx     (data_rx),
    .wfifo       (u_if.master),
    .frame_err   (frame_err),
    .rx_overflow (rx_overflow),
    .rx_busy     (rx_busy)
  );

  always #5 s_clk = ~s_clk;

  ev_t        exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge s_clk);
    #1;
  endtask

  task automatic bit_period(input logic v);
    data_rx = v;
    wait_cycles(BT + 1);
  endtask

  task automatic push_ev(input ev_kind_e k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_v, input logic full);
    if (!stop_v) begin
      push_ev(EvErr, 8'h00);
    end else if (full) begin
      push_ev(EvOvf, exp_last);
    end else begin
      push_ev(EvWr, d);
      exp_last = d;
    end
    u_if.wfifo_full = full;
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) begin
      bit_period(d[i]);
    end
    bit_period(stop_v);
    u_if.wfifo_full = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_data"}, 32'(u_if.wfifo_wr_data), 32'h00);
    chk({tag, "_wr_en"}, 32'(u_if.wfifo_wr_en), 32'h0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    chk({tag, "_overflow"}, 32'(rx_overflow), 32'h0);
    chk({tag, "_busy"}, 32'(rx_busy), 32'h0);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  logic     prev_pulse = 1'b0;
  logic [2:0] pulses;
  ev_t      mon_e;
  int       got_kind;

  always @(negedge s_clk) begin
    if (s_rst_n === 1'b1) begin
      pulses = {u_if.wfifo_wr_en, frame_err, rx_overflow};
      if (pulses != 3'b000) begin
        chk("pulse_exclusive", 32'($countones(pulses)), 32'd1);
        chk("pulse_spacing", 32'(prev_pulse), 32'd0);
        got_kind = u_if.wfifo_wr_en ? 0 : (frame_err ? 1 : 2);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'(got_kind), 32'hFFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("event_kind", 32'(got_kind), 32'(mon_e.kind));
          if (mon_e.kind != EvErr) begin
            chk("event_wr_data", 32'(u_if.wfifo_wr_data), 32'(mon_e.data));
          end
        end
      end
      prev_pulse = (pulses != 3'b000);
    end else begin
      prev_pulse = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    data_rx         = 1'b1;
    u_if.wfifo_full = 1'b0;
    exp_last        = 8'h00;
    s_rst_n         = 1'b0;
    wait_cycles(3);
    chk_reset_vals("reset");
    s_rst_n = 1'b1;
    wait_cycles(5);

    // Single frame
    send_byte(8'h55, 1'b1, 1'b0);
    wait_cycles(20);
    chk("busy_after_55", 32'(rx_busy), 32'd0);
    chk("drain_55", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames, no idle gap after the stop bit
    send_byte(8'hA3, 1'b1, 1'b0);
    send_byte(8'h0F, 1'b1, 1'b0);
    wait_cycles(20);
    chk("drain_a3_0f", 32'(exp_q.size()), 32'd0);

    // Glitch shorter than half a bit
    data_rx = 1'b0;
    wait_cycles(4);
    chk("glitch_busy", 32'(rx_busy), 32'd1);
    data_rx = 1'b1;
    wait_cycles(30);
    chk("glitch_idle", 32'(rx_busy), 32'd0);

    // Framing error, then a good frame
    send_byte(8'h3C, 1'b0, 1'b0);
    bit_period(1'b1);
    send_byte(8'h81, 1'b1, 1'b0);
    wait_cycles(20);
    chk("drain_3c_81", 32'(exp_q.size()), 32'd0);

    // Overflow: byte dropped, wr_data keeps 8'h81
    send_byte(8'hFF, 1'b1, 1'b1);
    wait_cycles(20);
    chk("drain_ff", 32'(exp_q.size()), 32'd0);
    chk("ovf_wr_data_held", 32'(u_if.wfifo_wr_data), 32'h81);

    // Break: line held low -> one frame error, then wait for line high
    push_ev(EvErr, 8'h00);
    data_rx = 1'b0;
    wait_cycles(12 * (BT + 1));
    chk("break_idle", 32'(rx_busy), 32'd0);
    data_rx = 1'b1;
    wait_cycles(20);
    chk("drain_break", 32'(exp_q.size()), 32'd0);

    // Reset during bit 4 of 8'h96
    bit_period(1'b0);
    for (int i = 0; i < 4; i++) begin
      bit_period(logic'((8'h96 >> i) & 8'h01));
    end
    data_rx = 1'b1;
    wait_cycles(8);
    chk("midframe_busy", 32'(rx_busy), 32'd1);
    s_rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    wait_cycles(5);
    s_rst_n = 1'b1;
    exp_last = 8'h00;
    wait_cycles(5);
    send_byte(8'h69, 1'b1, 1'b0);
    wait_cycles(20);
    chk("post_reset_data", 32'(u_if.wfifo_wr_data), 32'h69);
    chk("drain_final", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
